alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational MIPS ALU: registered single-cycle logic/arith ops plus iterative multi-cycle MULT/DIV writing dedicated HI/LO registers, read back via MFHI/MFLO.
- Sits in EX stage of the MIPS datapath; control unit drives `start`/`ALU_Control` and stalls the pipeline on `busy`.
- Replaces the combinational divider/16x16 multiplier with one shared shift/add engine.

Parameters:
- WIDTH, 32, operand/result/HI/LO width (>=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  op request; accepted only when busy=0
- ALU_Control  input  4  opcode, sampled with start
- Read_data1  input  WIDTH  operand A, sampled with start
- Read_data2  input  WIDTH  operand B, sampled with start
- ALUresult  output  WIDTH  registered result, held until next completion
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse: ALUresult (and HI/LO) updated
- hi_out  output  WIDTH  HI register
- lo_out  output  WIDTH  LO register

Behaviour:
- Reset (async, reset_n=0): ALUresult=0, hi_out=0, lo_out=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-MULT/DIV aborts; HI/LO are not updated with partial results.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD (mod 2^WIDTH), 0110 SUB (A-B mod 2^WIDTH).
  - 0111 SLT (signed, result 1 or 0), 1100 NOR.
  - 1000 MULT (unsigned, {HI,LO}=A*B), 1001 DIV (unsigned, LO=A/B, HI=A%B).
  - 1010 MFHI (result=HI), 1011 MFLO (result=LO).
  - Any other opcode: result=0, done pulses, no HI/LO change.
- States: IDLE, MUL, DIV.
- IDLE, start=1, single-cycle op: ALUresult written at the same edge, done=1 for the following cycle. Latency 1. Back-to-back starts each cycle are legal; done stays high.
- MFHI/MFLO issued the cycle after a MULT/DIV done return the new HI/LO (no hazard).
- IDLE, start=1, MULT/DIV:
  - Operands latched, counter=0, busy=1 from the next cycle, state MUL or DIV.
  - One iteration per edge, WIDTH iterations total.
  - MUL: shift-add, radix-2, into a 2*WIDTH accumulator.
  - DIV: restoring, one quotient bit per edge, MSB first.
  - Final iteration edge: HI/LO written, ALUresult=LO, busy=0, done=1 next cycle, return to IDLE.
  - start asserted on that final edge is ignored (busy still 1).
  - start-to-done latency = WIDTH cycles.
- start while busy=1: ignored entirely (operands, opcode not sampled); in-flight op unaffected.
- DIV by zero: no special case. Restoring algorithm yields LO=all ones, HI=A, same latency.
- done is never asserted while busy=1. busy and done are mutually exclusive.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: extra output port `overflow` (1 bit, reset 0). Registered with done:
  - ADD: 1 on signed two's-complement overflow.
  - SUB: 1 on signed two's-complement overflow.
  - All other ops: 0.
- Undefined: port absent; no overflow logic.

Test Plan:
- ADD 0x7FFF_FFFF + 1 (WIDTH=32) -> ALUresult=0x8000_0000, done 1 cycle after start; with ALU_OVF_EN, overflow=1. SUB 5-7 -> 0xFFFF_FFFE.
- SLT A=0xFFFF_FFFF, B=1 -> 1; swap -> 0. NOR 0,0 -> 0xFFFF_FFFF.
- MULT 0x0001_0000 * 0x0001_0003 -> busy for 32 cycles, then HI=0x1, LO=0x0003_0000, done one cycle. Next-cycle MFHI -> 0x1.
- DIV 100/7 -> LO=14, HI=2 after 32 cycles. DIV 5/0 -> LO=0xFFFF_FFFF, HI=5.
- During MULT, pulse start with ADD 1+1 -> ignored; MULT result unchanged; no extra done pulse.
- Assert reset_n=0 at iteration 10 of DIV -> busy=0, HI=LO=0 immediately. Fresh DIV afterwards completes correctly.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered MIPS ALU with iterative MULT/DIV into HI/LO; optional ALU_OVF_EN adds an overflow output
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] Read_data1,
    input  logic [WIDTH-1:0] Read_data2,
    output logic [WIDTH-1:0] ALUresult,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
`ifdef ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       counter;
    logic [2*WIDTH-1:0]     acc;
    logic [WIDTH-1:0]       opb;

    logic [WIDTH-1:0]       sum;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH-1:0]       single_res;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_rem;
    logic [2*WIDTH-1:0]     acc_next;
    logic                   last_iter;

    always_comb begin
        sum  = Read_data1 + Read_data2;
        diff = Read_data1 - Read_data2;
        single_res = '0;
        case (ALU_Control)
            OP_AND:  single_res = Read_data1 & Read_data2;
            OP_OR:   single_res = Read_data1 | Read_data2;
            OP_ADD:  single_res = sum;
            OP_SUB:  single_res = diff;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(Read_data1) < $signed(Read_data2))};
            OP_NOR:  single_res = ~(Read_data1 | Read_data2);
            OP_MFHI: single_res = hi_out;
            OP_MFLO: single_res = lo_out;
            default: single_res = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    logic ovf_c;
    always_comb begin
        ovf_c = 1'b0;
        if (ALU_Control == OP_ADD)
            ovf_c = (Read_data1[WIDTH-1] == Read_data2[WIDTH-1]) && (sum[WIDTH-1] != Read_data1[WIDTH-1]);
        else if (ALU_Control == OP_SUB)
            ovf_c = (Read_data1[WIDTH-1] != Read_data2[WIDTH-1]) && (diff[WIDTH-1] != Read_data1[WIDTH-1]);
    end
`endif

    // Shared engine: MUL keeps {partial, multiplier}, DIV keeps {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb}) : div_shift[WIDTH-1:0];
        if (state == S_MUL)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else
            acc_next = {div_rem, acc[WIDTH-2:0], div_ge};
    end

    assign last_iter = (counter == CNT_W'(WIDTH-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            counter   <= '0;
            acc       <= '0;
            opb       <= '0;
            ALUresult <= '0;
            hi_out    <= '0;
            lo_out    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ALU_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (ALU_Control == OP_MULT) begin
                            state   <= S_MUL;
                            acc     <= {{WIDTH{1'b0}}, Read_data2};
                            opb     <= Read_data1;
                            counter <= '0;
                            busy    <= 1'b1;
                        end else if (ALU_Control == OP_DIV) begin
                            state   <= S_DIV;
                            acc     <= {{WIDTH{1'b0}}, Read_data1};
                            opb     <= Read_data2;
                            counter <= '0;
                            busy    <= 1'b1;
                        end else begin
                            ALUresult <= single_res;
                            done      <= 1'b1;
`ifdef ALU_OVF_EN
                            overflow  <= ovf_c;
`endif
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc     <= acc_next;
                    counter <= counter + CNT_W'(1);
                    if (last_iter) begin
                        hi_out    <= acc_next[2*WIDTH-1:WIDTH];
                        lo_out    <= acc_next[WIDTH-1:0];
                        ALUresult <= acc_next[WIDTH-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_IDLE;
`ifdef ALU_OVF_EN
                        overflow  <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq; ALU_OVF_EN also checks overflow
module tb_alu_seq;

    localparam int W = 32;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
        logic         multi;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [3:0]   ALU_Control;
    logic [W-1:0] Read_data1, Read_data2;
    logic [W-1:0] ALUresult, hi_out, lo_out;
    logic         busy, done;
`ifdef ALU_OVF_EN
    logic         overflow;
`endif

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ALU_Control(ALU_Control),
        .Read_data1(Read_data1), .Read_data2(Read_data2), .ALUresult(ALUresult),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
`ifdef ALU_OVF_EN
        , .overflow(overflow)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: pushes what the DUT should report on completion
    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        logic [W-1:0] r;
        e = '0;
        e.hi = m_hi;
        e.lo = m_lo;
        case (op)
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_ADD:  begin r = a + b; e.res = r; e.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            OP_SUB:  begin r = a - b; e.res = r; e.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            OP_NOR:  e.res = ~(a | b);
            OP_MULT: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.res = e.lo; e.multi = 1'b1;
            end
            OP_DIV: begin
                if (b == 0) begin e.lo = '1; e.hi = a; end
                else begin e.lo = a / b; e.hi = a % b; end
                e.res = e.lo; e.multi = 1'b1;
            end
            OP_MFHI: e.res = m_hi;
            OP_MFLO: e.res = m_lo;
            default: e.res = '0;
        endcase
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
        ALU_Control = op;
        Read_data1  = a;
        Read_data2  = b;
        start       = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        drive(op, a, b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int pre);
        int cyc = pre;
        int bc = pre;
        exp_t e;
        while (!done && cyc < 100) begin
            if (busy) bc++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, cyc, e.multi ? W : 0);
            check({tag, "_busycyc"}, bc, e.multi ? W : 0);
            check({tag, "_res"}, ALUresult, e.res);
            check({tag, "_hi"}, hi_out, e.hi);
            check({tag, "_lo"}, lo_out, e.lo);
`ifdef ALU_OVF_EN
            check({tag, "_ovf"}, overflow, e.ovf);
`endif
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        ALU_Control = '0;
        Read_data1 = '0;
        Read_data2 = '0;
        #12;
        check("rst_res", ALUresult, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1);    wait_done("add_ovf", 0);
        check("add_lit", ALUresult, 32'h8000_0000);
        do_op(OP_SUB, 32'd5, 32'd7);            wait_done("sub", 0);
        check("sub_lit", ALUresult, 32'hFFFF_FFFE);
        do_op(OP_SUB, 32'h8000_0000, 32'd1);    wait_done("sub_ovf", 0);
        do_op(OP_SLT, 32'hFFFF_FFFF, 32'd1);    wait_done("slt", 0);
        do_op(OP_SLT, 32'd1, 32'hFFFF_FFFF);    wait_done("slt_swap", 0);
        do_op(OP_NOR, 32'd0, 32'd0);            wait_done("nor", 0);
        do_op(OP_AND, 32'hF0F0_1234, 32'hFF00_FF0F); wait_done("and", 0);
        do_op(OP_OR,  32'h0F00_0001, 32'h0000_F010); wait_done("or", 0);
        do_op(4'b0011, 32'hDEAD_BEEF, 32'h1);  wait_done("bad_op", 0);

        @(negedge clk);
        drive(OP_ADD, 32'd3, 32'd4);
        @(negedge clk);
        wait_done("b2b_1", 0);
        drive(OP_OR, 32'h10, 32'h01);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_2", 0);

        do_op(OP_MULT, 32'h0001_0000, 32'h0001_0003);
        drive(OP_ADD, 32'd1, 32'd1);
        void'(sb.pop_back());
        @(negedge clk);
        start = 1'b0;
        wait_done("mult", 1);
        check("mult_hi_lit", hi_out, 32'h1);
        check("mult_lo_lit", lo_out, 32'h0003_0000);
        do_op(OP_MFHI, 32'd0, 32'd0);           wait_done("mfhi", 0);
        check("mfhi_lit", ALUresult, 32'h1);
        @(negedge clk);
        check("no_extra_done", done, 0);
        check("res_held", ALUresult, 32'h1);

        do_op(OP_DIV, 32'd100, 32'd7);          wait_done("div", 0);
        check("div_lo_lit", lo_out, 32'd14);
        check("div_hi_lit", hi_out, 32'd2);
        do_op(OP_MFLO, 32'd0, 32'd0);           wait_done("mflo", 0);
        do_op(OP_DIV, 32'd5, 32'd0);            wait_done("div0", 0);
        do_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("mult_max", 0);
        for (int i = 0; i < 2; i++) begin
            do_op(OP_MULT, $urandom, $urandom); wait_done("mult_rnd", 0);
            do_op(OP_DIV, $urandom, $urandom_range(1, 70000)); wait_done("div_rnd", 0);
        end

        do_op(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi_out, 0);
        check("abort_lo", lo_out, 0);
        check("abort_done", done, 0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        do_op(OP_DIV, 32'd100, 32'd7);          wait_done("div_after_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
